rs_error_corrector: RTL and testbench

// - S3 stage of the RS(544,514) decoder. Sits directly downstream of the Forney wrapper.
// - Collects (pos, y) error events for one codeword into an error table.
// - Once the Forney done indication arrives, streams the buffered received codeword and

---
 rtl/rs_error_corrector.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_rs_error_corrector.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_error_corrector.sv
// Purpose : RS(544,514) S3 stage; buffers Forney (pos, y) events, then XORs them into the streamed codeword.
// Latency : 1 cycle from codeword beat handshake to out_vld_o (single registered output stage).
// Backpr. : cw_rdy_o = ~out_vld_o | out_rdy_i while applying; err_rdy_o low until the codeword's last beat is taken.
//
// Ports:
//   clk_i, rst_ni (async, active low), flush_i (sync abort of table/state/output register)
//   err_*      : Forney event stream (valid/ready), accepted only while collecting
//   recorrect_done_i : level, all events of the current codeword delivered
//   cw_*       : buffered received codeword, LANES symbols per beat, lane l = bits [l*W +: W]
//   out_*      : corrected beats with per-codeword fail flag and accepted-event count
// Optional: define RS_CORR_STATS_EN to add stat_cw_o / stat_fail_o / stat_sym_o counters.

module rs_error_corrector #(
    parameter int unsigned LANES = 32,
    parameter int unsigned W     = 10,
    parameter int unsigned N     = 544,
    parameter int unsigned T     = 15,
    parameter int unsigned POS_W = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 err_vld_i,
    output logic                 err_rdy_o,
    input  logic [POS_W-1:0]     err_pos_i,
    input  logic [W-1:0]         err_y_i,
    input  logic                 err_den_zero_i,
    input  logic                 recorrect_done_i,
    input  logic                 cw_vld_i,
    output logic                 cw_rdy_o,
    input  logic [LANES*W-1:0]   cw_data_i,
    input  logic                 cw_last_i,
    output logic                 out_vld_o,
    input  logic                 out_rdy_i,
    output logic [LANES*W-1:0]   out_data_o,
    output logic                 out_last_o,
    output logic                 out_fail_o,
    output logic [4:0]           out_err_cnt_o
`ifdef RS_CORR_STATS_EN
    ,
    output logic [31:0]          stat_cw_o,
    output logic [31:0]          stat_fail_o,
    output logic [31:0]          stat_sym_o
`endif
);

    localparam int unsigned NBEATS = (N + LANES - 1) / LANES;
    localparam int unsigned BEAT_W = $clog2(NBEATS);
    localparam logic [4:0]  CNT_T   = 5'(T);
    localparam logic [4:0]  CNT_OVF = 5'(T + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_APPLY   = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic err_rdy;
    logic cw_rdy;

    // error table
    logic [POS_W-1:0] tbl_pos [T];
    logic [W-1:0]     tbl_y   [T];
    logic [T-1:0]     tbl_vld;
    logic [4:0]       err_cnt;
    logic             fail;
    logic [BEAT_W-1:0] beat_cnt;

    logic ev_acc;
    logic cw_acc;
    logic ev_bad;
    logic tbl_full;
    logic beat_force;
    logic cw_end;

    logic [W-1:0]       corr [LANES];
    logic [POS_W-1:0]   base_pos;
    logic [LANES*W-1:0] data_nxt;

    assign ev_acc   = err_vld_i & err_rdy;
    assign cw_acc   = cw_vld_i & cw_rdy;
    assign ev_bad   = err_den_zero_i | (32'(err_pos_i) >= N);
    assign tbl_full = (err_cnt >= CNT_T);

    // A codeword that runs to its final beat index without a last marker is
    // terminated here anyway, and flagged as failed.
    assign beat_force = (beat_cnt == LAST_BEAT) & ~cw_last_i;
    assign cw_end     = cw_last_i | beat_force;

    //--------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_COLLECT;
        end else if (flush_i) begin
            state <= S_COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    //--------------------------------------------------------------------
    // FSM: next state
    //--------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_COLLECT: if (recorrect_done_i)   state_nxt = S_APPLY;
            S_APPLY:   if (cw_acc && cw_end)   state_nxt = S_COLLECT;
            default:                           state_nxt = S_COLLECT;
        endcase
    end

    //--------------------------------------------------------------------
    // FSM: outputs
    //--------------------------------------------------------------------
    always_comb begin
        err_rdy = 1'b0;
        cw_rdy  = 1'b0;
        case (state)
            S_COLLECT: err_rdy = 1'b1;
            S_APPLY:   cw_rdy  = ~out_vld_o | out_rdy_i;
            default: begin
                err_rdy = 1'b0;
                cw_rdy  = 1'b0;
            end
        endcase
    end

    assign err_rdy_o = err_rdy;
    assign cw_rdy_o  = cw_rdy;

    //--------------------------------------------------------------------
    // Table, event counter, fail flag and beat counter
    //--------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < T; e++) begin
                tbl_pos[e] <= '0;
                tbl_y[e]   <= '0;
            end
            tbl_vld  <= '0;
            err_cnt  <= '0;
            fail     <= 1'b0;
            beat_cnt <= '0;
        end else if (flush_i) begin
            for (int e = 0; e < T; e++) begin
                tbl_pos[e] <= '0;
                tbl_y[e]   <= '0;
            end
            tbl_vld  <= '0;
            err_cnt  <= '0;
            fail     <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (ev_acc) begin
                for (int e = 0; e < T; e++) begin
                    if (!tbl_full && (err_cnt == 5'(e))) begin
                        tbl_pos[e] <= err_pos_i;
                        tbl_y[e]   <= err_y_i;
                        tbl_vld[e] <= 1'b1;
                    end
                end
                // A (T+1)-th event is dropped; the count parks at T+1 so the
                // reported count never exceeds that value.
                err_cnt <= tbl_full ? CNT_OVF : err_cnt + 5'd1;
                if (ev_bad || tbl_full) begin
                    fail <= 1'b1;
                end
            end
            if (cw_acc) begin
                if (cw_end) begin
                    tbl_vld  <= '0;
                    err_cnt  <= '0;
                    fail     <= 1'b0;
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
            end
        end
    end

    //--------------------------------------------------------------------
    // Per-lane correction: XOR of every valid entry whose position lands on
    // (beat_cnt, lane). Duplicated positions accumulate naturally.
    //--------------------------------------------------------------------
    always_comb begin
        base_pos = POS_W'(32'(beat_cnt) * LANES);
        for (int l = 0; l < LANES; l++) begin
            corr[l] = '0;
            for (int e = 0; e < T; e++) begin
                if (tbl_vld[e] && (tbl_pos[e] == base_pos + POS_W'(l))) begin
                    corr[l] = corr[l] ^ tbl_y[e];
                end
            end
        end
    end

    // Failed codewords pass through untouched.
    always_comb begin
        data_nxt = cw_data_i;
        if (!fail) begin
            for (int l = 0; l < LANES; l++) begin
                data_nxt[l*W +: W] = cw_data_i[l*W +: W] ^ corr[l];
            end
        end
    end

    //--------------------------------------------------------------------
    // Output register; holds while the downstream stalls because cw_rdy
    // drops whenever out_vld_o=1 and out_rdy_i=0.
    //--------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_o     <= 1'b0;
            out_data_o    <= '0;
            out_last_o    <= 1'b0;
            out_fail_o    <= 1'b0;
            out_err_cnt_o <= '0;
        end else if (flush_i) begin
            out_vld_o     <= 1'b0;
            out_data_o    <= '0;
            out_last_o    <= 1'b0;
            out_fail_o    <= 1'b0;
            out_err_cnt_o <= '0;
        end else if (cw_acc) begin
            out_vld_o     <= 1'b1;
            out_data_o    <= data_nxt;
            out_last_o    <= cw_end;
            out_fail_o    <= fail | beat_force;
            // err_cnt saturates at T+1, so it already equals min(err_cnt, T+1)
            out_err_cnt_o <= err_cnt;
        end else if (out_rdy_i) begin
            out_vld_o     <= 1'b0;
        end
    end

`ifdef RS_CORR_STATS_EN
    //--------------------------------------------------------------------
    // Statistics
    //--------------------------------------------------------------------
    localparam int unsigned MODC_W = $clog2(LANES + 1);
    logic [MODC_W-1:0] mod_cnt;

    always_comb begin
        mod_cnt = '0;
        if (!fail) begin
            for (int l = 0; l < LANES; l++) begin
                if (corr[l] != '0) begin
                    mod_cnt = mod_cnt + MODC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_cw_o   <= '0;
            stat_fail_o <= '0;
            stat_sym_o  <= '0;
        end else if (flush_i) begin
            stat_cw_o   <= '0;
            stat_fail_o <= '0;
            stat_sym_o  <= '0;
        end else if (cw_acc) begin
            stat_sym_o <= stat_sym_o + 32'(mod_cnt);
            if (cw_end) begin
                stat_cw_o <= stat_cw_o + 32'd1;
                if (fail || beat_force) begin
                    stat_fail_o <= stat_fail_o + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rs_error_corrector.sv
module tb_rs_error_corrector;

    localparam int LANES = 32;
    localparam int W     = 10;
    localparam int N     = 544;
    localparam int T     = 15;
    localparam int POS_W = 10;
    localparam int NB    = 17;
    localparam int DW    = LANES * W;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          fail;
        logic [4:0]    cnt;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             err_vld = 1'b0;
    logic             err_rdy;
    logic [POS_W-1:0] err_pos = '0;
    logic [W-1:0]     err_y = '0;
    logic             err_dz = 1'b0;
    logic             done = 1'b0;
    logic             cw_vld = 1'b0;
    logic             cw_rdy;
    logic [DW-1:0]    cw_data = '0;
    logic             cw_last = 1'b0;
    logic             out_vld;
    logic             out_rdy = 1'b1;
    logic [DW-1:0]    out_data;
    logic             out_last;
    logic             out_fail;
    logic [4:0]       out_err_cnt;

    always #5 clk = ~clk;

    rs_error_corrector dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .err_vld_i        (err_vld),
        .err_rdy_o        (err_rdy),
        .err_pos_i        (err_pos),
        .err_y_i          (err_y),
        .err_den_zero_i   (err_dz),
        .recorrect_done_i (done),
        .cw_vld_i         (cw_vld),
        .cw_rdy_o         (cw_rdy),
        .cw_data_i        (cw_data),
        .cw_last_i        (cw_last),
        .out_vld_o        (out_vld),
        .out_rdy_i        (out_rdy),
        .out_data_o       (out_data),
        .out_last_o       (out_last),
        .out_fail_o       (out_fail),
        .out_err_cnt_o    (out_err_cnt)
    );

    int    errors = 0;
    int    checks = 0;
    beat_t exp_q[$];
    bit    sb_off = 1'b0;
    bit    rdy_rand = 1'b0;
    int    ev_pos[$];
    int    ev_y[$];
    bit    ev_dz[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic clr_ev();
        ev_pos.delete();
        ev_y.delete();
        ev_dz.delete();
    endtask

    task automatic add_ev(input int pos, input int y, input bit dz);
        ev_pos.push_back(pos);
        ev_y.push_back(y);
        ev_dz.push_back(dz);
    endtask

    // Waits for a handshake on the currently driven request. Ready is sampled
    // at the negedge; inputs are stable there, so it decides the next edge.
    task automatic wait_hs(input bit is_err, input string name);
        bit r;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            r = is_err ? err_rdy : cw_rdy;
            @(posedge clk);
            #1;
            if (r) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout_%s", name);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: flat symbol array, fail from the event list, XOR applied by position.
    task automatic run_cw(input bit rnd_data, input bit no_last, input int nbeats);
        logic [W-1:0]  sym     [N];
        logic [W-1:0]  ref_sym [N];
        logic [DW-1:0] d;
        beat_t         e;
        bit            fl;
        bit            co;
        int            n;
        int            cnt;
        n = ev_pos.size();
        for (int k = 0; k < N; k++) begin
            sym[k]     = rnd_data ? W'($urandom) : W'(k);
            ref_sym[k] = sym[k];
        end
        fl = (n > T);
        for (int i = 0; i < n; i++) begin
            if (ev_dz[i] || ev_pos[i] >= N) fl = 1'b1;
        end
        cnt = (n > T + 1) ? T + 1 : n;
        if (!fl) begin
            for (int i = 0; i < n; i++) ref_sym[ev_pos[i]] = ref_sym[ev_pos[i]] ^ W'(ev_y[i]);
        end
        if (!sb_off) begin
            for (int b = 0; b < NB; b++) begin
                for (int l = 0; l < LANES; l++) e.data[l*W +: W] = ref_sym[b*LANES + l];
                e.last = (b == NB - 1);
                e.fail = fl || (no_last && b == NB - 1);
                e.cnt  = 5'(cnt);
                exp_q.push_back(e);
            end
        end

        check("cw_rdy_in_collect", cw_rdy, 1'b0);

        co = (n > 0) && ($urandom_range(0, 1) == 1);
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 2));
            err_vld = 1'b1;
            err_pos = POS_W'(ev_pos[i]);
            err_y   = W'(ev_y[i]);
            err_dz  = ev_dz[i];
            done    = co && (i == n - 1);
            wait_hs(1'b1, "err");
            err_vld = 1'b0;
            err_dz  = 1'b0;
            done    = 1'b0;
        end
        if (!co) begin
            idle($urandom_range(0, 2));
            done = 1'b1;
            idle(1);
            done = 1'b0;
        end
        check("err_rdy_in_apply", err_rdy, 1'b0);

        for (int b = 0; b < nbeats; b++) begin
            idle($urandom_range(0, 2));
            for (int l = 0; l < LANES; l++) d[l*W +: W] = sym[b*LANES + l];
            cw_vld  = 1'b1;
            cw_data = d;
            cw_last = (b == NB - 1) && !no_last;
            if (b == NB - 1) check("err_rdy_before_last", err_rdy, 1'b0);
            wait_hs(1'b0, "cw");
            cw_vld  = 1'b0;
            cw_last = 1'b0;
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 1000; c++) begin
            if (exp_q.size() == 0 && !out_vld) return;
            idle(1);
        end
        checks++;
        errors++;
        $display("FAIL timeout_drain pending=%0d", exp_q.size());
    endtask

    // downstream ready
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_rdy = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // monitor / scoreboard
    beat_t mon_got;
    beat_t mon_exp;
    beat_t mon_held;
    bit    mon_stalled = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            mon_got = {out_data, out_last, out_fail, out_err_cnt};
            if (!rst_n || flush || sb_off) begin
                mon_stalled = 1'b0;
                continue;
            end
            if (mon_stalled) begin
                checks++;
                if (!out_vld || mon_got !== mon_held) begin
                    errors++;
                    $display("FAIL hold vld=%b got=%h want=%h", out_vld, mon_got, mon_held);
                end
            end
            mon_stalled = 1'b0;
            if (out_vld && out_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got=%h", mon_got);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL beat data got=%h want=%h last %b/%b fail %b/%b cnt %0d/%0d",
                                 mon_got.data, mon_exp.data, mon_got.last, mon_exp.last,
                                 mon_got.fail, mon_exp.fail, mon_got.cnt, mon_exp.cnt);
                    end
                end
            end else if (out_vld) begin
                mon_stalled = 1'b1;
                mon_held    = mon_got;
            end
        end
    end

    initial begin
        #12;
        check("rst_err_rdy", err_rdy, 1'b1);
        check("rst_cw_rdy", cw_rdy, 1'b0);
        check("rst_out_vld", out_vld, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_fail", out_fail, 1'b0);
        check("rst_out_data_zero", 64'(out_data != '0), 64'd0);
        check("rst_out_err_cnt", out_err_cnt, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // no errors, incrementing data
        clr_ev();
        run_cw(1'b0, 1'b0, NB);
        // single error
        clr_ev();
        add_ev(33, 'h155, 1'b0);
        run_cw(1'b0, 1'b0, NB);
        // boundary positions
        clr_ev();
        add_ev(0, $urandom_range(1, 1023), 1'b0);
        add_ev(31, $urandom_range(1, 1023), 1'b0);
        add_ev(543, $urandom_range(1, 1023), 1'b0);
        run_cw(1'b1, 1'b0, NB);
        // overflow: T+1 events
        clr_ev();
        for (int i = 0; i < T + 1; i++) add_ev($urandom_range(0, N - 1), $urandom_range(1, 1023), 1'b0);
        run_cw(1'b1, 1'b0, NB);
        // denominator zero
        clr_ev();
        add_ev(40, 'h0AA, 1'b1);
        run_cw(1'b1, 1'b0, NB);
        // out of range
        clr_ev();
        add_ev(600, 'h0AA, 1'b0);
        run_cw(1'b1, 1'b0, NB);
        // duplicate positions accumulate
        clr_ev();
        add_ev(100, 'h003, 1'b0);
        add_ev(100, 'h005, 1'b0);
        add_ev(200, 'h3FF, 1'b0);
        run_cw(1'b1, 1'b0, NB);
        // beat counter overrun: no last marker
        clr_ev();
        run_cw(1'b1, 1'b1, NB);

        // random events with downstream backpressure, back-to-back
        rdy_rand = 1'b1;
        for (int c = 0; c < 6; c++) begin
            clr_ev();
            repeat ($urandom_range(0, 16)) begin
                add_ev(($urandom_range(0, 19) == 0) ? 600 : $urandom_range(0, N - 1),
                       $urandom_range(1, 1023), ($urandom_range(0, 19) == 0));
            end
            run_cw(1'b1, 1'b0, NB);
        end
        rdy_rand = 1'b0;
        drain();

        // flush in the middle of a codeword
        sb_off = 1'b1;
        clr_ev();
        add_ev(5, 'h001, 1'b0);
        run_cw(1'b1, 1'b0, 6);
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        check("flush_out_vld", out_vld, 1'b0);
        check("flush_out_last", out_last, 1'b0);
        check("flush_out_fail", out_fail, 1'b0);
        check("flush_out_data_zero", 64'(out_data != '0), 64'd0);
        check("flush_out_err_cnt", out_err_cnt, 5'd0);
        check("flush_err_rdy", err_rdy, 1'b1);
        check("flush_cw_rdy", cw_rdy, 1'b0);
        sb_off = 1'b0;
        idle(1);
        // table must be empty after the flush
        clr_ev();
        run_cw(1'b1, 1'b0, NB);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
